// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus layouts, access sizes
// and the memory-access sequencing states.
package mem_stage_pkg;

  localparam int EXE_TO_MEM_WIDTH = 139;
  localparam int MEM_TO_WB_WIDTH  = 70;
  localparam int XLEN             = 64;

  // Field positions in the execute-to-mem bus (MSB first).
  localparam int EXE_MEM_REN_BIT = 138;
  localparam int EXE_MEM_WEN_BIT = 137;
  localparam int EXE_SIZE_LSB    = 135;
  localparam int EXE_SEXT_BIT    = 134;
  localparam int EXE_REG_WEN_BIT = 133;
  localparam int EXE_RD_LSB      = 128;
  localparam int EXE_ALU_LSB     = 64;
  localparam int EXE_SDATA_LSB   = 0;

  // Field positions in the mem-to-wb bus.
  localparam int WB_REG_WEN_BIT = 69;
  localparam int WB_RD_LSB      = 64;
  localparam int WB_WDATA_LSB   = 0;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational byte-lane steering: store mask/data placement and load
// extraction with sign or zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] sh;

  always_comb begin
    shamt = {off, 3'b000};
    wdata = store_data << shamt;
    sh    = rdata >> shamt;

    // Misaligned accesses simply lose the lanes shifted past byte 7.
    case (size)
      SZ_B:    wmask = 8'h01 << off;
      SZ_H:    wmask = 8'h03 << off;
      SZ_W:    wmask = 8'h0F << off;
      SZ_D:    wmask = 8'hFF;
      default: wmask = 8'hFF;
    endcase

    case (size)
      SZ_B:    load_data = {{56{sext & sh[7]}},  sh[7:0]};
      SZ_H:    load_data = {{48{sext & sh[15]}}, sh[15:0]};
      SZ_W:    load_data = {{32{sext & sh[31]}}, sh[31:0]};
      SZ_D:    load_data = sh;
      default: load_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: holds one execute-stage entry, performs its load or
// store over the data-memory port and hands the result to write-back.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        exe_to_mem_valid,
  input  logic [EXE_TO_MEM_WIDTH-1:0] exe_to_mem_bus,
  output logic                        mem_allowin,
  input  logic                        wb_allowin,
  output logic                        mem_to_wb_valid,
  output logic [MEM_TO_WB_WIDTH-1:0]  mem_to_wb_bus,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [63:0]                 dmem_addr,
  output logic [63:0]                 dmem_wdata,
  output logic [7:0]                  dmem_wmask,
  input  logic                        dmem_req_ready,
  input  logic                        dmem_rvalid,
  input  logic [63:0]                 dmem_rdata
);

  logic                        mem_valid_q, mem_valid_d;
  logic [EXE_TO_MEM_WIDTH-1:0] entry_q, entry_d;
  mem_state_e                  state_q, state_d;
  logic [63:0]                 rdata_q, rdata_d;

  logic        ready_go;
  logic        retire;
  logic        capture;

  logic        e_ren, e_wen, e_sext, e_reg_wen, e_is_mem;
  logic [1:0]  e_size;
  logic [4:0]  e_rd;
  logic [63:0] e_alu, e_sdata;
  logic [63:0] load_data;

  assign e_ren     = entry_q[EXE_MEM_REN_BIT];
  assign e_wen     = entry_q[EXE_MEM_WEN_BIT];
  assign e_size    = entry_q[EXE_SIZE_LSB +: 2];
  assign e_sext    = entry_q[EXE_SEXT_BIT];
  assign e_reg_wen = entry_q[EXE_REG_WEN_BIT];
  assign e_rd      = entry_q[EXE_RD_LSB +: 5];
  assign e_alu     = entry_q[EXE_ALU_LSB +: XLEN];
  assign e_sdata   = entry_q[EXE_SDATA_LSB +: XLEN];
  assign e_is_mem  = e_ren | e_wen;

  mem_lane_align u_align (
    .off        (e_alu[2:0]),
    .size       (e_size),
    .sext       (e_sext),
    .store_data (e_sdata),
    .rdata      (rdata_q),
    .wmask      (dmem_wmask),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  // Request fields come straight from the held entry, so they stay stable
  // for as long as dmem_req is waiting on dmem_req_ready.
  assign dmem_we   = e_wen;
  assign dmem_addr = e_alu;

  always_comb begin
    mem_to_wb_bus = '0;
    mem_to_wb_bus[WB_REG_WEN_BIT]      = e_reg_wen & ~e_wen;
    mem_to_wb_bus[WB_RD_LSB +: 5]      = e_rd;
    mem_to_wb_bus[WB_WDATA_LSB +: XLEN] = e_ren ? load_data : e_alu;
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    dmem_req = 1'b0;
    ready_go = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_go = ~e_is_mem;
        dmem_req = mem_valid_q & e_is_mem;
        if (dmem_req && dmem_req_ready) begin
          state_d = e_wen ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_go = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_to_wb_valid = mem_valid_q & ready_go;
    mem_allowin     = ~mem_valid_q | (ready_go & wb_allowin);
    retire          = mem_to_wb_valid & wb_allowin;
    capture         = exe_to_mem_valid & mem_allowin;

    if (state_q == ST_DONE && retire) begin
      state_d = ST_IDLE;
    end

    // Capture wins over retire so a new entry can follow in the same cycle.
    if (capture) begin
      mem_valid_d = 1'b1;
    end else if (retire) begin
      mem_valid_d = 1'b0;
    end else begin
      mem_valid_d = mem_valid_q;
    end
    entry_d = capture ? exe_to_mem_bus : entry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      mem_valid_q <= mem_valid_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand sequences
// for multi-cycle corners, and random transactions against a byte-level model.
module tb_mem_stage;

  logic          clk = 1'b0;
  logic          rst;
  logic          exe_to_mem_valid;
  logic [138:0]  exe_to_mem_bus;
  logic          mem_allowin;
  logic          wb_allowin;
  logic          mem_to_wb_valid;
  logic [69:0]   mem_to_wb_bus;
  logic          dmem_req;
  logic          dmem_we;
  logic [63:0]   dmem_addr;
  logic [63:0]   dmem_wdata;
  logic [7:0]    dmem_wmask;
  logic          dmem_req_ready;
  logic          dmem_rvalid;
  logic [63:0]   dmem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .mem_allowin      (mem_allowin),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wmask       (dmem_wmask),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata)
  );

  typedef struct {
    string       nm;
    logic        ren;
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic        rwen;
    logic [4:0]  rd;
    logic [63:0] addr;
    logic [63:0] sd;
    logic [63:0] rdata;
    int          req_dly;
    int          rv_dly;
    int          bp;
    logic [7:0]  mask;
    logic [63:0] dwdata;
    logic [63:0] out;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: bytes [off, off+n) of the doubleword, clipped at byte 7.
  function automatic logic [7:0] m_mask(input logic [1:0] size, input int off);
    logic [7:0] m;
    int n;
    m = '0;
    n = 1 << size;
    for (int i = 0; i < 8; i++) begin
      if (size == 2'd3) m[i] = 1'b1;
      else m[i] = (i >= off) && (i < off + n);
    end
    return m;
  endfunction

  function automatic logic [63:0] m_sdata(input logic [63:0] sd, input int off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (i + off < 8) w[8*(i+off) +: 8] = sd[8*i +: 8];
    end
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [1:0] size,
                                         input logic sext, input int off);
    logic [63:0] v;
    logic [7:0]  b;
    int n;
    v = '0;
    b = '0;
    n = 1 << size;
    for (int j = 0; j < n; j++) begin
      b = (off + j < 8) ? rd[8*(off+j) +: 8] : 8'h00;
      v[8*j +: 8] = b;
    end
    if (sext && b[7]) begin
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    logic [69:0] exp_bus;
    int cyc;
    exp_bus = {v.rwen & ~v.wen, v.rd, v.out};
    @(negedge clk);
    chk({v.nm, " allowin_idle"}, mem_allowin, 1'b1);
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = {v.ren, v.wen, v.size, v.sext, v.rwen, v.rd, v.addr, v.sd};
    wb_allowin       = (v.bp == 0);
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus   = {11'h0, rnd64(), rnd64()};
    if (v.ren || v.wen) begin
      cyc = 0;
      while (!dmem_req && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      chk({v.nm, " req_seen"}, dmem_req, 1'b1);
      for (int i = 0; i < v.req_dly; i++) begin
        chk({v.nm, " allowin_busy"}, mem_allowin, 1'b0);
        @(negedge clk);
        chk({v.nm, " req_held"}, dmem_req, 1'b1);
        chk({v.nm, " addr_held"}, dmem_addr, v.addr);
      end
      chk({v.nm, " addr"}, dmem_addr, v.addr);
      chk({v.nm, " we"}, dmem_we, v.wen);
      if (v.wen) begin
        chk({v.nm, " wmask"}, dmem_wmask, v.mask);
        chk({v.nm, " wdata"}, dmem_wdata, v.dwdata);
      end
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk({v.nm, " req_dropped"}, dmem_req, 1'b0);
      if (v.ren) begin
        for (int i = 0; i < v.rv_dly; i++) begin
          chk({v.nm, " wait_valid"}, mem_to_wb_valid, 1'b0);
          chk({v.nm, " wait_allowin"}, mem_allowin, 1'b0);
          @(negedge clk);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = rnd64();
      end
    end else begin
      chk({v.nm, " no_req"}, dmem_req, 1'b0);
    end
    cyc = 0;
    while (!mem_to_wb_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.nm, " out_valid"}, mem_to_wb_valid, 1'b1);
    for (int i = 0; i < v.bp; i++) begin
      chk({v.nm, " bp_valid"}, mem_to_wb_valid, 1'b1);
      chk({v.nm, " bp_bus"}, mem_to_wb_bus, exp_bus);
      chk({v.nm, " bp_allowin"}, mem_allowin, 1'b0);
      @(negedge clk);
    end
    wb_allowin = 1'b1;
    #1;
    chk({v.nm, " out_bus"}, mem_to_wb_bus, exp_bus);
    chk({v.nm, " allowin_retire"}, mem_allowin, 1'b1);
    @(negedge clk);
    chk({v.nm, " retired"}, mem_to_wb_valid, 1'b0);
  endtask

  vec_t vecs[8];
  vec_t rv;
  logic [69:0] b2b_bus[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus   = '0;
    wb_allowin       = 1'b1;
    dmem_req_ready   = 1'b0;
    dmem_rvalid      = 1'b0;
    dmem_rdata       = 64'h5A5A_5A5A_5A5A_5A5A;

    //                nm          ren wen sz sx rw rd  addr                     sd                       rdata                    rq rv bp mask   dwdata                   out
    vecs[0] = '{"ld_b_sext",  1, 0, 0, 1, 1, 7,  64'h8000_0003,           64'h0,                   64'h0000_0000_8000_0000, 2, 2, 0, 8'h00, 64'h0,                   64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{"st_h",       0, 1, 1, 0, 1, 9,  64'h8000_0006,           64'h0000_0000_0000_ABCD, 64'h0,                   0, 0, 0, 8'hC0, 64'hABCD_0000_0000_0000, 64'h8000_0006};
    vecs[2] = '{"ld_w_zext",  1, 0, 2, 0, 1, 3,  64'h8000_0004,           64'h0,                   64'hDEAD_BEEF_0000_0000, 0, 0, 0, 8'h00, 64'h0,                   64'h0000_0000_DEAD_BEEF};
    vecs[3] = '{"ld_d_bp",    1, 0, 3, 0, 1, 12, 64'h0000_1000,           64'h0,                   64'h0123_4567_89AB_CDEF, 1, 1, 4, 8'h00, 64'h0,                   64'h0123_4567_89AB_CDEF};
    vecs[4] = '{"st_b",       0, 1, 0, 0, 0, 1,  64'h0000_2005,           64'h0000_0000_0000_0077, 64'h0,                   0, 0, 0, 8'h20, 64'h0000_7700_0000_0000, 64'h0000_2005};
    vecs[5] = '{"st_d_bp",    0, 1, 3, 0, 1, 2,  64'h0000_3008,           64'h1122_3344_5566_7788, 64'h0,                   3, 0, 2, 8'hFF, 64'h1122_3344_5566_7788, 64'h0000_3008};
    vecs[6] = '{"ld_h_sext",  1, 0, 1, 1, 1, 31, 64'h0000_4002,           64'h0,                   64'h0000_0000_8001_0000, 0, 3, 0, 8'h00, 64'h0,                   64'hFFFF_FFFF_FFFF_8001};
    vecs[7] = '{"ld_b_zext",  1, 0, 0, 0, 1, 4,  64'h0000_5000,           64'h0,                   64'h0000_0000_0000_00FF, 0, 0, 1, 8'h00, 64'h0,                   64'h0000_0000_0000_00FF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", mem_to_wb_valid, 1'b0);
    chk("reset_req", dmem_req, 1'b0);
    chk("reset_allowin", mem_allowin, 1'b1);
    rst = 1'b0;

    // Back-to-back ALU pass-through entries, one retiring per cycle.
    b2b_bus[0] = {1'b1, 5'd5,  64'h1234};
    b2b_bus[1] = {1'b1, 5'd6,  64'hCAFE_0000_0000_0001};
    b2b_bus[2] = {1'b0, 5'd17, 64'h0000_0000_FFFF_0000};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i - 1), mem_to_wb_valid, 1'b1);
        chk($sformatf("b2b%0d_bus", i - 1), mem_to_wb_bus, b2b_bus[i-1]);
        chk($sformatf("b2b%0d_allowin", i - 1), mem_allowin, 1'b1);
        chk($sformatf("b2b%0d_noreq", i - 1), dmem_req, 1'b0);
      end
      if (i < 3) begin
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = {5'b00000, b2b_bus[i][69], b2b_bus[i][68:64], b2b_bus[i][63:0], rnd64()};
      end else begin
        exe_to_mem_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_drained", mem_to_wb_valid, 1'b0);

    foreach (vecs[k]) begin
      do_txn(vecs[k]);
      $display("vec %s done (checks=%0d errors=%0d)", vecs[k].nm, n_checks, n_err);
    end

    // Reset while waiting for a load response.
    @(negedge clk);
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = {1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd8, 64'h0000_6000, 64'h0};
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    chk("rstwait_req", dmem_req, 1'b1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rstwait_inwait_req", dmem_req, 1'b0);
    chk("rstwait_inwait_allowin", mem_allowin, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_valid", mem_to_wb_valid, 1'b0);
    chk("rstwait_req_after", dmem_req, 1'b0);
    chk("rstwait_allowin", mem_allowin, 1'b1);
    rst = 1'b0;
    do_txn(vecs[2]);
    $display("reset-in-wait sequence done (checks=%0d errors=%0d)", n_checks, n_err);

    for (int t = 0; t < 150; t++) begin
      int op;
      int off;
      op         = $urandom_range(0, 2);
      rv.nm      = $sformatf("rnd%0d", t);
      rv.ren     = (op == 1);
      rv.wen     = (op == 2);
      rv.size    = 2'($urandom_range(0, 3));
      rv.sext    = 1'($urandom_range(0, 1));
      rv.rwen    = 1'($urandom_range(0, 1));
      rv.rd      = 5'($urandom_range(0, 31));
      rv.addr    = rnd64();
      rv.sd      = rnd64();
      rv.rdata   = rnd64();
      rv.req_dly = $urandom_range(0, 3);
      rv.rv_dly  = $urandom_range(0, 3);
      rv.bp      = $urandom_range(0, 2);
      off        = int'(rv.addr[2:0]);
      rv.mask    = m_mask(rv.size, off);
      rv.dwdata  = m_sdata(rv.sd, off);
      rv.out     = rv.ren ? m_load(rv.rdata, rv.size, rv.sext, off) : rv.addr;
      do_txn(rv);
      $display("%s op=%0d size=%0d off=%0d out=%h (errors=%0d)", rv.nm, op, rv.size, off, rv.out, n_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage: accepts an execute-stage entry over a valid/allowin handshake and performs its load or store on a data-memory request/response port.
- Drives the 70-bit {reg_wen, rd, wdata} bus to the write-back/register-file stage using that stage's valid/allowin protocol; this block is the producer end of that interface.
- One entry in flight; the 3-state FSM sequences memory access and back-pressure.

Parameters:
- EXE_TO_MEM_WIDTH, 139, {mem_ren, mem_wen, mem_size[1:0], mem_sext, reg_wen, rd[4:0], alu_result[63:0], store_data[63:0]}, MSB first.
- MEM_TO_WB_WIDTH, 70, {reg_wen, rd[4:0], wdata[63:0]}, MSB first.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- exe_to_mem_valid  in  1  upstream entry valid
- exe_to_mem_bus  in  139  upstream entry payload
- mem_allowin  out  1  this stage can accept an entry this cycle
- wb_allowin  in  1  downstream can accept
- mem_to_wb_valid  out  1  downstream entry valid
- mem_to_wb_bus  out  70  downstream payload
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  64  byte address (alu_result)
- dmem_wdata  out  64  lane-aligned store data
- dmem_wmask  out  8  byte-lane write enables
- dmem_req_ready  in  1  request accepted when dmem_req && dmem_req_ready
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  64  load response data, full aligned doubleword

Behaviour:
- Reset: mem_valid=0, FSM=IDLE, mem_to_wb_valid=0, dmem_req=0, mem_allowin=1. Bus register contents don't-care.
- Entry capture: when exe_to_mem_valid && mem_allowin, register the bus and set mem_valid=1. Otherwise mem_valid stays 1 until the entry retires.
- mem_allowin = !mem_valid || (ready_go && wb_allowin).
- mem_to_wb_valid = mem_valid && ready_go. An entry retires when mem_to_wb_valid && wb_allowin. A new entry may be captured in the same cycle (back-to-back throughput of 1/cycle for non-memory ops).
- Non-memory entry (mem_ren=mem_wen=0): ready_go=1 immediately; wdata=alu_result.
- FSM states:
  - IDLE: if mem_valid && (mem_ren || mem_wen), assert dmem_req. On acceptance, a store goes to DONE and a load goes to WAIT.
  - WAIT: dmem_req=0. On dmem_rvalid, latch dmem_rdata and go to DONE. dmem_rvalid arrives no earlier than the cycle after acceptance.
  - DONE: ready_go=1. On retire go to IDLE; a newly captured memory entry issues its request the next cycle.
- ready_go for memory ops is 1 only in DONE. Request acceptance is not a combinational ready_go.
- dmem_req is held with stable addr/we/wdata/wmask until accepted. It is never deasserted before acceptance.
- Byte lane off = alu_result[2:0].
  - Store mask by size: 0 -> 0x01<<off; 1 -> 0x03<<off; 2 -> 0x0F<<off; 3 -> 0xFF.
  - dmem_wdata = store_data << (8*off).
- Load data: sh = dmem_rdata >> (8*off), truncated to 8/16/32/64 bits by size. If mem_sext, sign-extend; otherwise zero-extend to 64.
- Output bus = {reg_wen & !mem_wen, rd, ld ? extended load : alu_result}. reg_wen is forced 0 for stores.
- Misaligned accesses (off not a multiple of the access size) are outside this block's contract. Mask and data follow the formulas above with no trap.
- Reset mid-operation returns to IDLE with mem_valid=0. The memory shares rst, so no stale response arrives after reset.
- While wb_allowin=0 in DONE, the output bus and valid hold stable.

Decomposition:
- Shared package: bus widths, bit-field offsets for both buses, size encodings (B=0, H=1, W=2, D=3), FSM state constants.
- One natural sub-module: mem_lane_align, a combinational store mask/data shifter plus load extract/extend, unit-testable on its own.

Test Plan:
- ALU pass-through: entry reg_wen=1, rd=5, alu_result=0x1234, wb_allowin=1 -> next cycle mem_to_wb_valid=1, bus={1,5,0x1234}; three back-to-back entries retire in consecutive cycles.
- Signed byte load: addr=0x80000003, size=0, sext=1, dmem_rdata=0x00000000_80000000, dmem_req_ready delayed 2 cycles, rvalid 3 cycles later -> wdata=0xFFFF_FFFF_FFFF_FF80; mem_allowin=0 throughout.
- Store half: addr=0x80000006, store_data=0xABCD -> dmem_wmask=0xC0, dmem_wdata=0xABCD_0000_0000_0000, dmem_we=1; output reg_wen=0.
- Back-pressure: load completes with wb_allowin=0 for 4 cycles -> bus and valid stable, mem_allowin=0; retires the cycle wb_allowin=1.
- Unsigned word load: off=4, sext=0, rdata=0xDEADBEEF_00000000 -> wdata=0x00000000_DEADBEEF.
- Reset while in WAIT -> next cycle mem_valid=0, dmem_req=0, mem_allowin=1; the next entry processes normally.
